// File: rtl/hs_elastic_fifo.sv
// hs_elastic_fifo: clocked elastic buffer between a req/ack source and a req/ack sink.
// Upstream: requests with req_l and captures din on an ack_l pulse.
// Downstream: answers req_r with a one-cycle ack_r carrying dout.
// Optional build macro HS_ELASTIC_FIFO_STATS_EN adds push/pop counters and a high-water mark.
module hs_elastic_fifo #(
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 4,
    localparam int unsigned addr_w    = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_l,
    input  logic                  ack_l,
    input  logic [data_width-1:0] din,
    input  logic                  req_r,
    output logic                  ack_r,
    output logic [data_width-1:0] dout,
    output logic [addr_w:0]       count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
`ifdef HS_ELASTIC_FIFO_STATS_EN
    ,
    output logic [31:0]           push_count,
    output logic [31:0]           pop_count,
    output logic [addr_w:0]       max_count
`endif
);

    localparam int unsigned cnt_w = addr_w + 1;
    localparam logic [cnt_w-1:0] cnt_full    = cnt_w'(depth);
    // Keep one slot spare for an ack_l landing the cycle after req_l drops.
    localparam logic [cnt_w-1:0] cnt_req_max = cnt_w'(depth - 2);

    logic [data_width-1:0] mem_q [depth];
    logic [addr_w-1:0]     wr_ptr_q, wr_ptr_d;
    logic [addr_w-1:0]     rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]      count_q, count_d;
    logic                  req_l_q, req_l_d;
    logic                  ack_r_q, ack_r_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  push, pop;

    // Next-state: accept/drop incoming word, issue a pop at most every other cycle.
    always_comb begin
        push       = ack_l && (count_q != cnt_full);
        // Pop only from words already stored; no same-cycle bypass of din.
        pop        = req_r && !ack_r_q && (count_q != '0);
        wr_ptr_d   = push ? wr_ptr_q + addr_w'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + addr_w'(1) : rd_ptr_q;
        count_d    = count_q + cnt_w'(push) - cnt_w'(pop);
        ack_r_d    = pop;
        dout_d     = pop ? mem_q[rd_ptr_q] : dout_q;
        req_l_d    = (count_d <= cnt_req_max);
        empty_d    = (count_d == '0);
        full_d     = (count_d == cnt_full);
        overflow_d = overflow_q || (ack_l && (count_q == cnt_full));
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            req_l_q    <= 1'b0;
            ack_r_q    <= 1'b0;
            dout_q     <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            req_l_q    <= req_l_d;
            ack_r_q    <= ack_r_d;
            dout_q     <= dout_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign req_l    = req_l_q;
    assign ack_r    = ack_r_q;
    assign dout     = dout_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overflow = overflow_q;

`ifdef HS_ELASTIC_FIFO_STATS_EN
    logic [31:0]      push_count_q, push_count_d;
    logic [31:0]      pop_count_q, pop_count_d;
    logic [cnt_w-1:0] max_count_q, max_count_d;

    // Statistics next-state: dropped words are not counted.
    always_comb begin
        push_count_d = push_count_q + 32'(push);
        pop_count_d  = pop_count_q + 32'(pop);
        max_count_d  = (count_d > max_count_q) ? count_d : max_count_q;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_count_q <= '0;
            pop_count_q  <= '0;
            max_count_q  <= '0;
        end else begin
            push_count_q <= push_count_d;
            pop_count_q  <= pop_count_d;
            max_count_q  <= max_count_d;
        end
    end

    assign push_count = push_count_q;
    assign pop_count  = pop_count_q;
    assign max_count  = max_count_q;
`endif

endmodule
